// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the frame-based FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_MAX_FRAME = 1518;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_winner+1 (wrapping)
// and returns a one-hot winner plus a valid flag.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] winner,
  output logic               winner_valid
);

  always_comb begin
    int idx;
    idx          = 0;
    winner       = '0;
    winner_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_winner) + i) % NUM_REQ;
      if (!winner_valid && req[idx]) begin
        winner[idx]  = 1'b1;
        winner_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter feeding a shared FIFO: one requester owns the
// write port from first word to last word (or MAX_FRAME truncation), then a one-cycle gap.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int MAX_FRAME = DEF_MAX_FRAME
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]                req_last,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              write_to_fifo,
  output logic [DATA_SIZE-1:0]              write_data_in,
  input  logic                              full,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              frame_done,
  output logic                              frame_err
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = $clog2(MAX_FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_FRAME - 1);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;

  logic [NUM_REQ-1:0] rr_winner;
  logic               rr_valid;
  logic [IDX_W-1:0]   rr_idx;
  logic               xfer;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req          (req_valid),
    .last_winner  (last_winner_q),
    .winner       (rr_winner),
    .winner_valid (rr_valid)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_winner[i]) rr_idx = IDX_W'(i);
    end
  end

  // Data path is combinational from the owner's inputs; only XFER ever opens it.
  assign xfer          = (state_q == XFER);
  assign accept        = xfer & req_valid[owner_q] & ~full;
  assign grant         = grant_q;
  assign req_ready     = (xfer && !full) ? grant_q : '0;
  assign write_to_fifo = accept;
  assign write_data_in = xfer ? req_data[owner_q] : '0;
  assign frame_done    = frame_done_q;
  assign frame_err     = frame_err_q;

  always_comb begin
    // NOTE: every *_d gets a default before the case so no latch is inferred.
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_winner_d = last_winner_q;
    cnt_d         = cnt_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_winner;
          owner_d = rr_idx;
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          // A real last word wins over truncation when both land on word MAX_FRAME.
          if (req_last[owner_q]) begin
            frame_done_d = 1'b1;
            grant_d      = '0;
            state_d      = GAP;
          end else if (cnt_q == LAST_CNT) begin
            frame_err_d = 1'b1;
            grant_d     = '0;
            state_d     = GAP;
          end
        end
      end
      GAP: begin
        last_winner_d = owner_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: frame sources per channel, expected writes/grants/frame events
// queued at stimulus time and popped as the arbiter produces them.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    int          ch;
    logic [DW-1:0] data;
    logic        last;
  } word_t;

  logic                 clk;
  logic                 rst_n;
  logic                 full;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_last;
  logic [N-1:0][DW-1:0] req_data;

  logic [N-1:0]  ready_a, grant_a, ready_b, grant_b;
  logic          wr_a, wr_b, done_a, done_b, err_a, err_b;
  logic [DW-1:0] wd_a, wd_b;

  logic          use_m4;
  logic [N-1:0]  ready_s, grant_s;
  logic          wr_s, done_s, err_s;
  logic [DW-1:0] wd_s;

  int n_checks, n_fail;
  int n_wr, n_done, n_err, n_stall, cyc;
  int stall_at, stall_len, full_hold, frame_seed;
  bit stall_armed;
  logic [N-1:0] prev_grant;

  word_t src_q[$];
  word_t exp_wr[$];
  int    exp_grant[$];
  bit    exp_evt[$];   // 0 = frame_done, 1 = frame_err
  int    gstart_q[$];

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_a), .write_to_fifo(wr_a),
    .write_data_in(wd_a), .full(full), .grant(grant_a),
    .frame_done(done_a), .frame_err(err_a)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_SIZE(DW), .MAX_FRAME(4)) dut_m4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_b), .write_to_fifo(wr_b),
    .write_data_in(wd_b), .full(full), .grant(grant_b),
    .frame_done(done_b), .frame_err(err_b)
  );

  always_comb begin
    ready_s = use_m4 ? ready_b : ready_a;
    grant_s = use_m4 ? grant_b : grant_a;
    wr_s    = use_m4 ? wr_b    : wr_a;
    done_s  = use_m4 ? done_b  : done_a;
    err_s   = use_m4 ? err_b   : err_a;
    wd_s    = use_m4 ? wd_b    : wd_a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    logic [N-1:0] seen;
    seen      = '0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    foreach (src_q[i]) begin
      if (!seen[src_q[i].ch]) begin
        seen[src_q[i].ch]      = 1'b1;
        req_valid[src_q[i].ch] = 1'b1;
        req_data[src_q[i].ch]  = src_q[i].data;
        req_last[src_q[i].ch]  = src_q[i].last;
      end
    end
  endtask

  task automatic pop_ch(input int ch);
    int k;
    k = -1;
    foreach (src_q[i]) if (k < 0 && src_q[i].ch == ch) k = i;
    if (k >= 0) src_q.delete(k);
  endtask

  task automatic send_frame(input int ch, input int nw, input bit with_last);
    word_t e;
    for (int w = 0; w < nw; w++) begin
      e.ch   = ch;
      e.data = DW'(ch * 40 + w + 1 + frame_seed);
      e.last = with_last && (w == nw - 1);
      src_q.push_back(e);
      exp_wr.push_back(e);
    end
    frame_seed += 7;
    drive();
  endtask

  task automatic monitor();
    word_t e;
    int    g;
    bit    k;
    if (wr_s) begin
      n_wr++;
      if (exp_wr.size() == 0) check("wr_extra", 32'(wr_s), 32'(0));
      else begin
        e = exp_wr.pop_front();
        check("wr_data", 32'(wd_s), 32'(e.data));
        check("wr_owner", 32'(grant_s), 32'(1) << e.ch);
      end
    end
    if (full) begin
      n_stall++;
      check("stall_no_wr", 32'(wr_s), 32'(0));
    end
    if (grant_s != '0 && prev_grant == '0) begin
      gstart_q.push_back(cyc);
      if (exp_grant.size() == 0) check("grant_extra", 32'(grant_s), 32'(0));
      else begin
        g = exp_grant.pop_front();
        check("grant_order", 32'(grant_s), 32'(1) << g);
      end
    end
    if (grant_s != '0 && prev_grant != '0) check("grant_hold", 32'(grant_s), 32'(prev_grant));
    if (done_s || err_s) begin
      n_done += int'(done_s);
      n_err  += int'(err_s);
      if (exp_evt.size() == 0) check("evt_extra", 32'({done_s, err_s}), 32'(0));
      else begin
        k = exp_evt.pop_front();
        check("evt_kind", 32'({done_s, err_s}), k ? 32'(1) : 32'(2));
      end
    end
    prev_grant = grant_s;
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    cyc++;
    hs = req_valid & ready_s;
    monitor();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) if (hs[c]) pop_ch(c);
    if (stall_armed && n_wr == stall_at) begin
      full_hold   = stall_len;
      stall_armed = 1'b0;
    end
    full = (full_hold > 0);
    if (full_hold > 0) full_hold--;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((src_q.size() + exp_wr.size() + exp_evt.size() + exp_grant.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(src_q.size() + exp_wr.size() + exp_evt.size() + exp_grant.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_q.delete();
    exp_wr.delete();
    exp_evt.delete();
    exp_grant.delete();
    gstart_q.delete();
    full        = 1'b0;
    full_hold   = 0;
    stall_armed = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant_s), 32'(0));
    check("rst_ready", 32'(ready_s), 32'(0));
    check("rst_wr", 32'({wr_s, done_s, err_s}), 32'(0));
    check("rst_wdata", 32'(wd_s), 32'(0));
    rst_n      = 1'b1;
    n_wr       = 0;
    n_done     = 0;
    n_err      = 0;
    n_stall    = 0;
    cyc        = 0;
    prev_grant = '0;
  endtask

  initial begin
    int k;
    n_checks   = 0;
    n_fail     = 0;
    frame_seed = 0;
    use_m4     = 1'b0;
    rst_n      = 1'b0;
    full       = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;

    // All four channels, two-word frames: strict 0,1,2,3 rotation.
    do_reset();
    for (int c = 0; c < N; c++) begin
      send_frame(c, 2, 1'b1);
      exp_grant.push_back(c);
      exp_evt.push_back(1'b0);
    end
    drain("t034_drain", 200);
    check("t034_writes", 32'(n_wr), 32'(8));
    check("t034_dones", 32'(n_done), 32'(4));

    // Channel 2 owns a 5-word frame; channel 0 arrives mid-frame and must wait.
    do_reset();
    send_frame(2, 5, 1'b1);
    exp_grant.push_back(2);
    exp_evt.push_back(1'b0);
    step();
    step();
    send_frame(0, 2, 1'b1);
    exp_grant.push_back(0);
    exp_evt.push_back(1'b0);
    drain("t035_drain", 200);

    // Ten cycles of back-pressure before word 3 of a 6-word frame.
    do_reset();
    stall_at    = 2;
    stall_len   = 10;
    stall_armed = 1'b1;
    send_frame(1, 6, 1'b1);
    exp_grant.push_back(1);
    exp_evt.push_back(1'b0);
    drain("t036_drain", 200);
    check("t036_stall_cycles", 32'(n_stall), 32'(10));
    check("t036_writes", 32'(n_wr), 32'(6));

    // Reset in the middle of word 2: outputs drop immediately, rotation restarts at 0.
    do_reset();
    send_frame(1, 3, 1'b1);
    exp_grant.push_back(1);
    k = 0;
    while (n_wr < 1 && k < 20) begin
      step();
      k++;
    end
    check("t038_reached_w2", 32'(n_wr), 32'(1));
    check("t038_pre_wr", 32'(wr_s), 32'(1));
    rst_n = 1'b0;
    #1;
    check("t038_grant", 32'(grant_s), 32'(0));
    check("t038_ready", 32'(ready_s), 32'(0));
    check("t038_wr", 32'({wr_s, done_s, err_s}), 32'(0));
    check("t038_wdata", 32'(wd_s), 32'(0));
    do_reset();
    send_frame(0, 2, 1'b1);
    send_frame(1, 2, 1'b1);
    exp_grant.push_back(0);
    exp_grant.push_back(1);
    exp_evt.push_back(1'b0);
    exp_evt.push_back(1'b0);
    drain("t038_drain", 200);

    // Single-word frames on channels 1 and 3: three cycles per frame.
    do_reset();
    send_frame(1, 1, 1'b1);
    send_frame(3, 1, 1'b1);
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    exp_evt.push_back(1'b0);
    exp_evt.push_back(1'b0);
    drain("t039_drain", 100);
    check("t039_nstarts", 32'(gstart_q.size()), 32'(2));
    if (gstart_q.size() >= 2) check("t039_spacing", 32'(gstart_q[1] - gstart_q[0]), 32'(3));

    // MAX_FRAME=4 instance: six words without early last -> truncation, then new frame.
    use_m4 = 1'b1;
    do_reset();
    send_frame(0, 6, 1'b1);
    exp_grant.push_back(0);
    exp_grant.push_back(0);
    exp_evt.push_back(1'b1);
    exp_evt.push_back(1'b0);
    drain("t037_drain", 200);
    check("t037_errs", 32'(n_err), 32'(1));
    check("t037_dones", 32'(n_done), 32'(1));
    use_m4 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
